unet_io_bridge: RTL and testbench

- Host-side feeder/collector sitting directly around unet_fsm_3_1.
- Buffers host-written weight and activation words, launches a run with unet_enpulse, and streams words onto data_in whenever the FSM requests them on ctrl.
- Captures data_out into a result FIFO while ctrl==DATA_READY and reports run completion and error status to the host.

---
 rtl/unet_pkg.sv | 21 ++
 rtl/unet_sync_fifo.sv | 70 +++++++
 rtl/unet_io_bridge.sv | 254 +++++++++++++++++++++++++
 tb/tb_unet_io_bridge.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unet_pkg.sv
// Constants shared by the unet_fsm_3_1 host bridge: default data width,
// the FSM request codes seen on ctrl, and the bridge's own state encoding.
package unet_pkg;

    // Default data word width, matching the FSM data_in/data_out ports.
    localparam int DW = 32;

    // Request codes driven by the FSM on ctrl; 5..7 behave like CALCULATING.
    localparam logic [2:0] CTRL_CALCULATING  = 3'd0;
    localparam logic [2:0] CTRL_SEND_WEIGHTS = 3'd1;
    localparam logic [2:0] CTRL_SEND_DATA    = 3'd2;
    localparam logic [2:0] CTRL_DATA_READY   = 3'd3;
    localparam logic [2:0] CTRL_SAY_IDLE     = 3'd4;

    // Bridge sequencer states.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/unet_sync_fifo.sv
// Single-clock first-word fall-through FIFO. The head word is visible on
// o_head whenever o_empty is low; a pop simply advances the read pointer.
// A push while full is accepted only when a pop happens in the same cycle.
module unet_sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [DW-1:0]          i_push_data,
    input  logic                   i_pop,
    output logic [DW-1:0]          o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign w_pop_ok  = i_pop && (r_count != '0);
    assign w_push_ok = i_push && ((r_count != FULL_COUNT) || w_pop_ok);

    // Storage write.
    // NOTE: the array has no reset; only pointers/count define what is valid,
    // which keeps it mappable onto RAM.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; depth is a power of two so the
    // pointers wrap on their own.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/unet_io_bridge.sv
// Host-side feeder/collector around unet_fsm_3_1. The host preloads weight
// and activation words, requests a run with start, and the bridge launches
// the FSM, answers its ctrl requests with registered data_in words, captures
// results into a FIFO, and reports completion, counts and sticky errors.
module unet_io_bridge import unet_pkg::*; #(
    parameter int DW     = unet_pkg::DW,
    parameter int WDEPTH = 64,
    parameter int DDEPTH = 64,
    parameter int RDEPTH = 64,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    // host write side
    input  logic          wr_valid,
    input  logic          wr_sel,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    // host control / status
    input  logic          start,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          clr_err,
    output logic          run_done,
    output logic          underrun,
    output logic          overflow,
    output logic [CW-1:0] n_w,
    output logic [CW-1:0] n_d,
    output logic [CW-1:0] n_r,
    // FSM side
    output logic          unet_enpulse,
    output logic [DW-1:0] data_in,
    input  logic [2:0]    ctrl,
    input  logic          busy,
    input  logic [DW-1:0] data_out
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    // Sequencer and registered outputs.
    logic [1:0]    r_state;
    logic          r_pending;
    logic          r_active;
    logic          r_enpulse;
    logic          r_run_done;
    logic [DW-1:0] r_data_in;
    logic [CW-1:0] r_n_w;
    logic [CW-1:0] r_n_d;
    logic [CW-1:0] r_n_r;
    logic          r_underrun;
    logic          r_overflow;

    // FIFO interfaces.
    logic                    w_w_push, w_w_pop, w_w_full, w_w_empty;
    logic                    w_d_push, w_d_pop, w_d_full, w_d_empty;
    logic                    w_r_push, w_r_pop, w_r_full, w_r_empty;
    logic [DW-1:0]           w_w_head, w_d_head, w_r_head;
    logic [$clog2(WDEPTH):0] w_w_count;
    logic [$clog2(DDEPTH):0] w_d_count;
    logic [$clog2(RDEPTH):0] w_r_count;
    logic                    w_unused_counts;

    // Request decode, valid only while a run is being served.
    logic w_serve;
    logic w_req_w;
    logic w_req_d;
    logic w_req_r;
    logic w_r_accept;
    logic w_err_under;
    logic w_err_over;

    assign w_serve = (r_state == ST_RUN);
    assign w_req_w = w_serve && (ctrl == CTRL_SEND_WEIGHTS);
    assign w_req_d = w_serve && (ctrl == CTRL_SEND_DATA);
    assign w_req_r = w_serve && (ctrl == CTRL_DATA_READY);

    // wr_ready stays low until the first clock after reset so every output
    // reads 0 while rst_n is asserted.
    assign wr_ready = r_active && (wr_sel ? !w_d_full : !w_w_full);
    assign w_w_push = wr_valid && wr_ready && !wr_sel;
    assign w_d_push = wr_valid && wr_ready &&  wr_sel;

    assign w_w_pop  = w_req_w && !w_w_empty;
    assign w_d_pop  = w_req_d && !w_d_empty;

    // A capture into a full result FIFO still lands if the host pops the
    // head in the same cycle.
    assign w_r_pop    = rd_ready && !w_r_empty;
    assign w_r_push   = w_req_r;
    assign w_r_accept = w_req_r && (!w_r_full || w_r_pop);

    assign w_err_under = (w_req_w && w_w_empty) || (w_req_d && w_d_empty);
    assign w_err_over  = w_req_r && !w_r_accept;

    // Occupancy counts are not needed by the bridge itself.
    assign w_unused_counts = ^{w_w_count, w_d_count, w_r_count};

    unet_sync_fifo #(.DW(DW), .DEPTH(WDEPTH)) u_weight_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_w_push),
        .i_push_data (wr_data),
        .i_pop       (w_w_pop),
        .o_head      (w_w_head),
        .o_full      (w_w_full),
        .o_empty     (w_w_empty),
        .o_count     (w_w_count)
    );

    unet_sync_fifo #(.DW(DW), .DEPTH(DDEPTH)) u_data_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_d_push),
        .i_push_data (wr_data),
        .i_pop       (w_d_pop),
        .o_head      (w_d_head),
        .o_full      (w_d_full),
        .o_empty     (w_d_empty),
        .o_count     (w_d_count)
    );

    unet_sync_fifo #(.DW(DW), .DEPTH(RDEPTH)) u_result_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_r_push),
        .i_push_data (data_out),
        .i_pop       (w_r_pop),
        .o_head      (w_r_head),
        .o_full      (w_r_full),
        .o_empty     (w_r_empty),
        .o_count     (w_r_count)
    );

    // Marks the first clock after reset release; gates wr_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // Run sequencer: IDLE -> LAUNCH -> RUN -> DONE -> IDLE, with a pending
    // latch so a start seen while the FSM is busy or a run is underway is
    // not lost. A start during LAUNCH re-arms pending rather than vanishing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pending  <= 1'b0;
            r_enpulse  <= 1'b0;
            r_run_done <= 1'b0;
        end else begin
            r_enpulse  <= 1'b0;
            r_run_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if ((start || r_pending) && !busy) begin
                        r_state <= ST_LAUNCH;
                    end else if (start) begin
                        r_pending <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    r_enpulse <= 1'b1;
                    r_pending <= start;
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (start) begin
                        r_pending <= 1'b1;
                    end
                    if (ctrl == CTRL_SAY_IDLE) begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        r_pending <= 1'b1;
                    end
                    r_run_done <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Word delivery to the FSM: the FIFO head is registered onto data_in on
    // the edge that samples the request; an empty source delivers 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_in <= '0;
        end else if (w_req_w) begin
            r_data_in <= w_w_empty ? '0 : w_w_head;
        end else if (w_req_d) begin
            r_data_in <= w_d_empty ? '0 : w_d_head;
        end
    end

    // Per-run saturating word counters, cleared at launch and held after DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_w <= '0;
            r_n_d <= '0;
            r_n_r <= '0;
        end else if (r_state == ST_LAUNCH) begin
            r_n_w <= '0;
            r_n_d <= '0;
            r_n_r <= '0;
        end else begin
            if (w_w_pop && (r_n_w != CNT_MAX)) begin
                r_n_w <= r_n_w + 1'b1;
            end
            if (w_d_pop && (r_n_d != CNT_MAX)) begin
                r_n_d <= r_n_d + 1'b1;
            end
            if (w_r_accept && (r_n_r != CNT_MAX)) begin
                r_n_r <= r_n_r + 1'b1;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_err_under) begin
                r_underrun <= 1'b1;
            end else if (clr_err) begin
                r_underrun <= 1'b0;
            end
            if (w_err_over) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign unet_enpulse = r_enpulse;
    assign run_done     = r_run_done;
    assign data_in      = r_data_in;
    assign n_w          = r_n_w;
    assign n_d          = r_n_d;
    assign n_r          = r_n_r;
    assign underrun     = r_underrun;
    assign overflow     = r_overflow;
    assign rd_valid     = !w_r_empty;
    // The head of an empty FIFO is stale memory; present 0 instead.
    assign rd_data      = w_r_empty ? '0 : w_r_head;

endmodule

// File: tb/tb_unet_io_bridge.sv
// Self-checking bench for unet_io_bridge. Directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_unet_io_bridge;

    localparam int DW     = 32;
    localparam int WDEPTH = 8;
    localparam int DDEPTH = 8;
    localparam int RDEPTH = 4;
    localparam int CW     = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_sel;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          start;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          clr_err;
    logic          run_done;
    logic          underrun;
    logic          overflow;
    logic [CW-1:0] n_w;
    logic [CW-1:0] n_d;
    logic [CW-1:0] n_r;
    logic          unet_enpulse;
    logic [DW-1:0] data_in;
    logic [2:0]    ctrl;
    logic          busy;
    logic [DW-1:0] data_out;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model state.
    logic [DW-1:0] wq[$];
    logic [DW-1:0] dq[$];
    logic [DW-1:0] rq[$];
    int            m_nw, m_nd, m_nr;
    bit            m_under, m_over, m_active, m_run;
    logic [DW-1:0] m_din;

    // Pulse counters sampled mid-cycle.
    int n_done = 0;
    int n_en   = 0;

    unet_io_bridge #(
        .DW(DW), .WDEPTH(WDEPTH), .DDEPTH(DDEPTH), .RDEPTH(RDEPTH), .CW(CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .start        (start),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .clr_err      (clr_err),
        .run_done     (run_done),
        .underrun     (underrun),
        .overflow     (overflow),
        .n_w          (n_w),
        .n_d          (n_d),
        .n_r          (n_r),
        .unet_enpulse (unet_enpulse),
        .data_in      (data_in),
        .ctrl         (ctrl),
        .busy         (busy),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (run_done === 1'b1)     n_done++;
        if (unet_enpulse === 1'b1) n_en++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        wq.delete(); dq.delete(); rq.delete();
        m_nw = 0; m_nd = 0; m_nr = 0;
        m_under = 0; m_over = 0; m_active = 0; m_run = 0;
        m_din = '0;
    endtask

    // Apply the current inputs to the model as one clock edge.
    task automatic model_edge();
        int wsz, dsz, rsz;
        bit host_w, host_d, rpop, rpush, err_u, err_o, leave;
        wsz = wq.size(); dsz = dq.size(); rsz = rq.size();
        host_w = wr_valid && m_active && !wr_sel && (wsz < WDEPTH);
        host_d = wr_valid && m_active &&  wr_sel && (dsz < DDEPTH);
        rpop   = rd_ready && (rsz > 0);
        rpush = 0; err_u = 0; err_o = 0; leave = 0;
        if (m_run) begin
            case (ctrl)
                3'd1: if (wsz > 0) begin
                          m_din = wq.pop_front();
                          if (m_nw < CNT_MAX) m_nw++;
                      end else begin
                          m_din = '0; err_u = 1;
                      end
                3'd2: if (dsz > 0) begin
                          m_din = dq.pop_front();
                          if (m_nd < CNT_MAX) m_nd++;
                      end else begin
                          m_din = '0; err_u = 1;
                      end
                3'd3: if (rsz < RDEPTH || rpop) begin
                          rpush = 1;
                          if (m_nr < CNT_MAX) m_nr++;
                      end else begin
                          err_o = 1;
                      end
                3'd4: leave = 1;
                default: ;
            endcase
        end
        if (rpop)   void'(rq.pop_front());
        if (rpush)  rq.push_back(data_out);
        if (host_w) wq.push_back(wr_data);
        if (host_d) dq.push_back(wr_data);
        if (err_u) m_under = 1; else if (clr_err) m_under = 0;
        if (err_o) m_over  = 1; else if (clr_err) m_over  = 0;
        m_active = 1;
        if (leave) m_run = 0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] exp_rd;
        bit            exp_wr;
        exp_rd = (rq.size() > 0) ? rq[0] : '0;
        exp_wr = m_active && (wr_sel ? (dq.size() < DDEPTH) : (wq.size() < WDEPTH));
        check($sformatf("%s.data_in", tag),  data_in,  m_din);
        check($sformatf("%s.n_w", tag),      n_w,      m_nw);
        check($sformatf("%s.n_d", tag),      n_d,      m_nd);
        check($sformatf("%s.n_r", tag),      n_r,      m_nr);
        check($sformatf("%s.underrun", tag), underrun, m_under);
        check($sformatf("%s.overflow", tag), overflow, m_over);
        check($sformatf("%s.rd_valid", tag), rd_valid, rq.size() > 0);
        check($sformatf("%s.rd_data", tag),  rd_data,  exp_rd);
        check($sformatf("%s.wr_ready", tag), wr_ready, exp_wr);
    endtask

    task automatic host_write(input bit sel, input logic [DW-1:0] d);
        wr_valid = 1; wr_sel = sel; wr_data = d;
        step();
        wr_valid = 0;
        check_all("write");
    endtask

    // Start pulse with busy low: enpulse must appear two cycles later.
    task automatic launch(input string tag);
        start = 1;
        step();
        start = 0;
        check($sformatf("%s.en_early", tag), unet_enpulse, 1'b0);
        step();
        check($sformatf("%s.en", tag), unet_enpulse, 1'b1);
        m_nw = 0; m_nd = 0; m_nr = 0; m_run = 1;
        check_all(tag);
    endtask

    task automatic finish_run(input string tag);
        int done0;
        done0 = n_done;
        ctrl = 3'd4;
        step();
        ctrl = 3'd0;
        check($sformatf("%s.done_early", tag), run_done, 1'b0);
        step();
        check($sformatf("%s.done", tag), run_done, 1'b1);
        step();
        check($sformatf("%s.done_end", tag), run_done, 1'b0);
        check($sformatf("%s.done_cnt", tag), n_done, done0 + 1);
        check_all(tag);
    endtask

    initial begin
        int en0, done0;
        rst_n = 0; wr_valid = 0; wr_sel = 0; wr_data = '0; start = 0;
        rd_ready = 0; clr_err = 0; ctrl = 3'd0; busy = 0; data_out = '0;
        model_reset();

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst.data_in",  data_in,      '0);
        check("rst.wr_ready", wr_ready,     1'b0);
        check("rst.rd_valid", rd_valid,     1'b0);
        check("rst.rd_data",  rd_data,      '0);
        check("rst.enpulse",  unet_enpulse, 1'b0);
        check("rst.run_done", run_done,     1'b0);
        check("rst.flags",    {underrun, overflow}, 2'b00);
        check("rst.counts",   {n_w, n_d, n_r}, '0);
        rst_n = 1;
        check_all("rst_rel");
        step();
        check_all("idle");

        // ---------------- basic run ----------------
        for (int i = 0; i < 4; i++) host_write(1'b0, 32'h11 + i);
        for (int i = 0; i < 3; i++) host_write(1'b1, 32'hA1 + i);
        en0 = n_en;
        launch("basic");
        ctrl = 3'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_all("basic.w");
            check($sformatf("basic.w%0d", i), data_in, 32'h11 + i);
        end
        check("basic.n_w", n_w, 4);
        ctrl = 3'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("basic.d");
            check($sformatf("basic.d%0d", i), data_in, 32'hA1 + i);
        end
        check("basic.n_d", n_d, 3);
        ctrl = 3'd3; data_out = 32'hBEEF;
        step();
        data_out = 32'hCAFE;
        step();
        ctrl = 3'd0;
        check_all("basic.r");
        check("basic.n_r", n_r, 2);
        finish_run("basic");
        check("basic.en_cnt", n_en, en0 + 1);
        check("basic.rd0", rd_data, 32'hBEEF);
        rd_ready = 1;
        step();
        check("basic.rd1", rd_data, 32'hCAFE);
        step();
        rd_ready = 0;
        check("basic.rd_empty", rd_valid, 1'b0);
        check_all("basic.drained");

        // ---------------- underrun ----------------
        host_write(1'b0, 32'h77);
        launch("ur");
        ctrl = 3'd1;
        step(); check_all("ur.0"); check("ur.w0", data_in, 32'h77);
        step(); check_all("ur.1"); check("ur.w1", data_in, 32'h0);
        step(); check_all("ur.2"); check("ur.w2", data_in, 32'h0);
        ctrl = 3'd0;
        check("ur.flag", underrun, 1'b1);
        check("ur.n_w", n_w, 1);
        clr_err = 1;
        step();
        clr_err = 0;
        check("ur.clr", underrun, 1'b0);
        finish_run("ur");

        // ---------------- pending start ----------------
        en0 = n_en;
        busy = 1; start = 1;
        step();
        start = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("pend.no_en", unet_enpulse, 1'b0);
        end
        busy = 0;
        step();
        check("pend.en_early", unet_enpulse, 1'b0);
        step();
        check("pend.en", unet_enpulse, 1'b1);
        m_nw = 0; m_nd = 0; m_nr = 0; m_run = 1;
        check_all("pend");
        finish_run("pend");
        check("pend.en_cnt", n_en, en0 + 1);

        // ---------------- overflow ----------------
        launch("ovf");
        ctrl = 3'd3;
        for (int i = 0; i < 6; i++) begin
            data_out = 32'h100 + i;
            step();
            check_all("ovf.cap");
        end
        ctrl = 3'd0;
        check("ovf.n_r", n_r, 4);
        check("ovf.flag", overflow, 1'b1);
        finish_run("ovf");
        rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf.rd%0d", i), rd_data, 32'h100 + i);
            step();
        end
        rd_ready = 0;
        check("ovf.empty", rd_valid, 1'b0);
        clr_err = 1;
        step();
        clr_err = 0;
        check_all("ovf.clr");

        // ---------------- randomized runs ----------------
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) begin
                wr_valid = 1'($urandom_range(0, 1));
                wr_sel   = 1'($urandom_range(0, 1));
                wr_data  = $urandom;
                step();
                check_all("rnd.fill");
            end
            wr_valid = 0;
            launch("rnd");
            for (int i = 0; i < 40; i++) begin
                ctrl = 3'($urandom_range(0, 7));
                if (ctrl == 3'd4) ctrl = 3'd0;
                data_out = $urandom;
                rd_ready = 1'($urandom_range(0, 1));
                wr_valid = 1'($urandom_range(0, 1));
                wr_sel   = 1'($urandom_range(0, 1));
                wr_data  = $urandom;
                clr_err  = ($urandom_range(0, 7) == 0);
                step();
                check_all("rnd.run");
            end
            ctrl = 3'd0; rd_ready = 0; wr_valid = 0; clr_err = 0;
            finish_run("rnd");
        end

        // ---------------- reset mid-run ----------------
        host_write(1'b0, 32'h5A5A0001);
        host_write(1'b0, 32'h5A5A0002);
        launch("mrst");
        ctrl = 3'd3; data_out = 32'hD00D;
        step(); check_all("mrst.r");
        ctrl = 3'd1;
        step(); check_all("mrst.w");
        done0 = n_done;
        #3;
        rst_n = 0;
        #1;
        check("mrst.data_in",  data_in,      '0);
        check("mrst.rd_valid", rd_valid,     1'b0);
        check("mrst.rd_data",  rd_data,      '0);
        check("mrst.wr_ready", wr_ready,     1'b0);
        check("mrst.counts",   {n_w, n_d, n_r}, '0);
        check("mrst.flags",    {underrun, overflow}, 2'b00);
        check("mrst.pulses",   {unet_enpulse, run_done}, 2'b00);
        model_reset();
        ctrl = 3'd0;
        @(posedge clk);
        #1;
        rst_n = 1;
        step();
        step();
        check("mrst.no_done", n_done, done0);
        check_all("mrst.idle");
        launch("mrst.relaunch");
        ctrl = 3'd1;
        step();
        ctrl = 3'd0;
        check_all("mrst.empty_w");
        finish_run("mrst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
